// File: rtl/tap_classifier_pkg.sv
// Shared types for the tap classifier: FSM state encoding and last_event codes.
package tap_classifier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        LOCK = 2'd2
    } tap_state_t;

    localparam logic [1:0] EV_NONE   = 2'b00;
    localparam logic [1:0] EV_SINGLE = 2'b01;
    localparam logic [1:0] EV_DOUBLE = 2'b10;

endpackage

// File: rtl/tap_classifier_sat_counter.sv
// Enable-driven incrementer that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/tap_classifier.sv
// Classifies debounced presses into single or double taps using a tick-based window,
// followed by a short lockout after each double tap.
module tap_classifier
    import tap_classifier_pkg::*;
#(
    parameter int WINDOW  = 4,
    parameter int LOCKOUT = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             press,
    input  logic             tick,
    output logic             single_tap,
    output logic             double_tap,
    output logic [1:0]       last_event,
    output logic [CNT_W-1:0] event_count,
    output logic             busy
);

    localparam int TMAX = (WINDOW > LOCKOUT) ? WINDOW : LOCKOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] WIN_LAST  = TW'(WINDOW - 1);
    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCKOUT - 1);

    tap_state_t    state;
    logic [TW-1:0] tcnt;
    logic          fire_single;
    logic          fire_double;

    // A press in WAIT beats a window-closing tick in the same cycle.
    assign fire_double = (state == WAIT) && press;
    assign fire_single = (state == WAIT) && !press && tick && (tcnt == WIN_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tcnt       <= '0;
            single_tap <= 1'b0;
            double_tap <= 1'b0;
            last_event <= EV_NONE;
        end else begin
            single_tap <= 1'b0;
            double_tap <= 1'b0;
            case (state)
                IDLE: begin
                    if (press) begin
                        state <= WAIT;
                        tcnt  <= '0;
                    end
                end
                WAIT: begin
                    if (fire_double) begin
                        double_tap <= 1'b1;
                        last_event <= EV_DOUBLE;
                        state      <= LOCK;
                        tcnt       <= '0;
                    end else if (fire_single) begin
                        single_tap <= 1'b1;
                        last_event <= EV_SINGLE;
                        state      <= IDLE;
                        tcnt       <= '0;
                    end else if (tick) begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                LOCK: begin
                    if (tick) begin
                        if (tcnt == LOCK_LAST) begin
                            state <= IDLE;
                            tcnt  <= '0;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tcnt  <= '0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

    sat_counter #(.W(CNT_W)) u_event_count (
        .clk   (clk),
        .reset (reset),
        .en    (fire_single || fire_double),
        .count (event_count)
    );

endmodule
